// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, SR/Cause field positions,
// exception codes and the exception vector.
package cp0_pkg;

  localparam logic [4:0] CP0_REG_COUNT   = 5'd9;
  localparam logic [4:0] CP0_REG_COMPARE = 5'd11;
  localparam logic [4:0] CP0_REG_SR      = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_REG_EPC     = 5'd14;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LO      = 10;
  localparam int SR_IM_HI      = 15;
  localparam int CAUSE_EXC_LO  = 2;
  localparam int CAUSE_EXC_HI  = 6;
  localparam int CAUSE_IP_LO   = 10;
  localparam int CAUSE_IP_HI   = 15;
  localparam int CAUSE_BD_BIT  = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] CP0_HANDLER_PC = 32'h0000_4180;

  // Restart address of a faulting instruction: a delay-slot instruction
  // restarts at its branch, and the result is always word aligned.
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    logic [31:0] t;
    t = bd ? (pc - 32'd4) : pc;
    return {t[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer for CP0; only instantiated when CP0_TIMER_EN is defined.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  logic [31:0] count_r;
  logic [31:0] compare_r;
  logic        pending_r;

  // Free-running counter, compare register and sticky match flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      pending_r <= 1'b0;
    end else begin
      count_r <= count_we ? wdata : (count_r + 32'd1);
      if (compare_we) begin
        compare_r <= wdata;
        pending_r <= 1'b0;
      end else if (count_r == compare_r) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign count   = count_r;
  assign compare = compare_r;
  assign pending = pending_r;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC, interrupt/exception request and eret target.
// Define CP0_TIMER_EN to add Count/Compare with the timer on hw_int[5].
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = CP0_HANDLER_PC,
  parameter logic [5:0]  IM_RESET   = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exccode,
  input  logic        m_eret,
  input  logic [5:0]  hw_int,
  output logic        req,
  output logic [31:0] epc_out
);

  if (HANDLER_PC[1:0] != 2'b00) begin : g_bad_vector
    $error("cp0_unit: HANDLER_PC must be word aligned");
  end

  logic [5:0]  im_r;
  logic        exl_r;
  logic        ie_r;
  logic [5:0]  ip_r;
  logic [4:0]  exccode_r;
  logic        bd_r;
  logic [31:0] epc_r;

  logic [5:0]  hw_eff_s;
  logic        int_req_s;
  logic        exc_req_s;
  logic        req_s;
  logic        wr_ok_s;
  logic [31:0] count_s;
  logic [31:0] compare_s;

`ifdef CP0_TIMER_EN
  logic        timer_pending_s;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (wr_ok_s && (cp0_addr == CP0_REG_COUNT)),
    .compare_we (wr_ok_s && (cp0_addr == CP0_REG_COMPARE)),
    .wdata      (cp0_wdata),
    .count      (count_s),
    .compare    (compare_s),
    .pending    (timer_pending_s)
  );

  assign hw_eff_s = {hw_int[5] | timer_pending_s, hw_int[4:0]};
`else
  assign count_s   = 32'd0;
  assign compare_s = 32'd0;
  assign hw_eff_s  = hw_int;
`endif

  // Live interrupt lines, not the registered IP, decide the request
  assign int_req_s = ie_r & ~exl_r & (|(hw_eff_s & im_r));
  assign exc_req_s = ~exl_r & (m_exccode != EXC_INT);
  assign req_s     = (int_req_s | exc_req_s) & reset;
  assign wr_ok_s   = cp0_we & ~req_s;
  assign req       = req_s;

  // mfc0 read mux over pre-edge register values
  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      CP0_REG_SR:    cp0_rdata = {16'd0, im_r, 8'd0, exl_r, ie_r};
      CP0_REG_CAUSE: cp0_rdata = {bd_r, 15'd0, ip_r, 3'd0, exccode_r, 2'd0};
      CP0_REG_EPC:   cp0_rdata = epc_r;
`ifdef CP0_TIMER_EN
      CP0_REG_COUNT:   cp0_rdata = count_s;
      CP0_REG_COMPARE: cp0_rdata = compare_s;
`endif
      default:       cp0_rdata = 32'd0;
    endcase
  end

  // Bypass a same-cycle mtc0 EPC so an immediately following eret sees it
  always_comb begin
    if (wr_ok_s && (cp0_addr == CP0_REG_EPC)) begin
      epc_out = {cp0_wdata[31:2], 2'b00};
    end else begin
      epc_out = epc_r;
    end
  end

  // SR, Cause and EPC update: exception entry, mtc0, eret
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_r      <= IM_RESET;
      exl_r     <= 1'b0;
      ie_r      <= 1'b0;
      ip_r      <= 6'd0;
      exccode_r <= 5'd0;
      bd_r      <= 1'b0;
      epc_r     <= 32'd0;
    end else begin
      ip_r <= hw_eff_s;
      if (req_s) begin
        exl_r     <= 1'b1;
        exccode_r <= int_req_s ? EXC_INT : m_exccode;
        bd_r      <= m_bd;
        epc_r     <= epc_of(m_pc, m_bd);
      end else begin
        if (wr_ok_s && (cp0_addr == CP0_REG_SR)) begin
          im_r <= cp0_wdata[SR_IM_HI:SR_IM_LO];
          ie_r <= cp0_wdata[SR_IE_BIT];
        end
        if (m_eret) begin
          exl_r <= 1'b0;
        end else if (wr_ok_s && (cp0_addr == CP0_REG_SR)) begin
          exl_r <= cp0_wdata[SR_EXL_BIT];
        end
        if (wr_ok_s && (cp0_addr == CP0_REG_EPC)) begin
          epc_r <= {cp0_wdata[31:2], 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed steps plus random traffic
// compared against a register-word level model of CP0.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        cp0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exccode;
  logic        m_eret;
  logic [5:0]  hw_int;
  logic        req;
  logic [31:0] epc_out;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] sr_m, cause_m, epc_m, cnt_m, cmp_m;
  logic        pend_m;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk       (clk),
    .reset     (reset),
    .cp0_we    (cp0_we),
    .cp0_addr  (cp0_addr),
    .cp0_wdata (cp0_wdata),
    .cp0_rdata (cp0_rdata),
    .m_pc      (m_pc),
    .m_bd      (m_bd),
    .m_exccode (m_exccode),
    .m_eret    (m_eret),
    .hw_int    (hw_int),
    .req       (req),
    .epc_out   (epc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sr_m = 32'd0; cause_m = 32'd0; epc_m = 32'd0;
    cnt_m = 32'd0; cmp_m = 32'd0; pend_m = 1'b0;
  endtask

  function automatic logic [31:0] rd_m(input logic [4:0] a);
    case (a)
      5'd12:   return sr_m;
      5'd13:   return cause_m;
      5'd14:   return epc_m;
`ifdef CP0_TIMER_EN
      5'd9:    return cnt_m;
      5'd11:   return cmp_m;
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock: drive, check combinational outputs, advance model at the edge
  task automatic step(input string tag, input logic we, input logic [4:0] addr,
                      input logic [31:0] wd, input logic [31:0] pc, input logic bd,
                      input logic [4:0] exc, input logic eret, input logic [5:0] hw);
    logic [5:0]  ipe;
    logic        ireq, rq, wr;
    logic [31:0] n_sr, n_cause, n_epc, n_cnt, n_cmp, ba;
    logic        n_pend;
    cp0_we = we; cp0_addr = addr; cp0_wdata = wd; m_pc = pc; m_bd = bd;
    m_exccode = exc; m_eret = eret; hw_int = hw;
    #2;
    ipe  = hw | {pend_m, 5'b00000};
    ireq = sr_m[0] && !sr_m[1] && ((ipe & sr_m[15:10]) != 6'd0);
    rq   = ireq || (!sr_m[1] && exc != 5'd0);
    wr   = we && !rq;
    chk({tag, "/req"}, {31'd0, req}, {31'd0, rq});
    chk({tag, "/epc_out"}, epc_out, (wr && addr == 5'd14) ? (wd & 32'hFFFF_FFFC) : epc_m);
    chk({tag, "/rdata"}, cp0_rdata, rd_m(addr));
    n_sr = sr_m; n_cause = cause_m; n_epc = epc_m;
    n_cause[15:10] = ipe;
    if (rq) begin
      n_sr[1] = 1'b1;
      n_cause[6:2] = ireq ? 5'd0 : exc;
      n_cause[31] = bd;
      ba = bd ? pc - 32'd4 : pc;
      n_epc = ba & 32'hFFFF_FFFC;
    end else begin
      if (wr && addr == 5'd12) n_sr = wd & 32'h0000_FC03;
      if (wr && addr == 5'd14) n_epc = wd & 32'hFFFF_FFFC;
      if (eret) n_sr[1] = 1'b0;
    end
    n_cnt = (wr && addr == 5'd9) ? wd : cnt_m + 32'd1;
    n_cmp = cmp_m; n_pend = pend_m;
    if (wr && addr == 5'd11) begin
      n_cmp = wd; n_pend = 1'b0;
    end else if (cnt_m == cmp_m) begin
      n_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    sr_m = n_sr; cause_m = n_cause; epc_m = n_epc;
`ifdef CP0_TIMER_EN
    cnt_m = n_cnt; cmp_m = n_cmp; pend_m = n_pend;
`endif
  endtask

  logic [4:0] addrs [7] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd3};
  logic [4:0] excs  [8] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd10, 5'd12};

  initial begin
    model_reset();
    reset = 1'b0;
    cp0_we = 1'b0; cp0_addr = 5'd12; cp0_wdata = 32'd0; m_pc = 32'd0; m_bd = 1'b0;
    m_exccode = 5'd12; m_eret = 1'b0; hw_int = 6'h3F;
    #2;
    chk("rst/req", {31'd0, req}, 32'd0);
    chk("rst/sr", cp0_rdata, 32'd0);
    cp0_addr = 5'd13; #1;
    chk("rst/cause", cp0_rdata, 32'd0);
    cp0_addr = 5'd14; #1;
    chk("rst/epc", cp0_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

    // interrupt entry
    step("tp2_mtc0",  1'b1, 5'd12, 32'h0000_FC01, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp2_int",   1'b0, 5'd14, 32'd0, 32'h3010, 1'b0, 5'd0, 1'b0, 6'b000100);
    step("tp2_after", 1'b0, 5'd14, 32'd0, 32'h3014, 1'b0, 5'd0, 1'b0, 6'b000100);
    step("tp2_cause", 1'b0, 5'd13, 32'd0, 32'h3018, 1'b0, 5'd0, 1'b0, 6'b000100);
    step("tp2_sr",    1'b0, 5'd12, 32'd0, 32'h301C, 1'b0, 5'd0, 1'b0, 6'd0);
    // delay-slot exception
    step("tp3_eret",  1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
    step("tp3_ie0",   1'b1, 5'd12, 32'h0000_FC00, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp3_exc",   1'b0, 5'd13, 32'd0, 32'h3024, 1'b1, 5'd12, 1'b0, 6'd0);
    step("tp3_epc",   1'b0, 5'd14, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp3_cause", 1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    // interrupt beats exception, mtc0 dropped
    step("tp4_eret",  1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
    step("tp4_sr",    1'b1, 5'd12, 32'h0000_FC01, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp4_both",  1'b1, 5'd12, 32'd0, 32'h3040, 1'b0, 5'd4, 1'b0, 6'b000001);
    step("tp4_cause", 1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp4_srchk", 1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    // EPC bypass then eret
    step("tp5_epcw",  1'b1, 5'd14, 32'h0000_3103, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp5_eret",  1'b0, 5'd14, 32'd0, 32'd0, 1'b0, 5'd0, 1'b1, 6'd0);
    step("tp5_sr",    1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);

    // mid-operation reset drops req immediately
    cp0_addr = 5'd12; hw_int = 6'b000001;
    #2;
    chk("mr/req_before", {31'd0, req},
        {31'd0, sr_m[0] & ~sr_m[1] & (|(sr_m[15:10] & 6'b000001))});
    reset = 1'b0;
    #1;
    chk("mr/req_during", {31'd0, req}, 32'd0);
    chk("mr/sr", cp0_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();

`ifdef CP0_TIMER_EN
    step("tp6_cmp",   1'b1, 5'd11, 32'd5, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp6_cnt",   1'b1, 5'd9,  32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp6_sr",    1'b1, 5'd12, 32'h0000_8001, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    for (int i = 0; i < 8; i++)
      step("tp6_run", 1'b0, 5'd9, 32'd0, 32'h5000, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp6_clr",   1'b1, 5'd11, 32'hFFFF_0000, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp6_ip1",   1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
    step("tp6_ip2",   1'b0, 5'd13, 32'd0, 32'd0, 1'b0, 5'd0, 1'b0, 6'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic        we, bd, er;
      logic [4:0]  ad, ex;
      logic [31:0] wd, pc;
      logic [5:0]  hw;
      we = ($urandom_range(0, 3) == 0);
      ad = addrs[$urandom_range(0, 6)];
      wd = $urandom;
      if (ad == 5'd12 && $urandom_range(0, 1) == 1) wd[1] = 1'b0;
      ex = excs[$urandom_range(0, 7)];
      er = ($urandom_range(0, 5) == 0);
      hw = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      pc = $urandom;
      bd = 1'($urandom);
      step("rand", we, ad, wd, pc, bd, ex, er, hw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 at the M-stage end of the E/M pipeline interface.
- Consumes the M-stage exception bundle (PC, BD, ExcCode, eret, CP0 write), samples hardware interrupts, and keeps SR/Cause/EPC.
- Drives the Req flush that sends the pipeline to the 0x4180 handler, and supplies EPC for eret.

Parameters:
HANDLER_PC, 32'h0000_4180, exception vector; exported for the PC mux, not used internally
IM_RESET, 6'b000000, reset value of SR.IM

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cp0_we  in  1  mtc0 write enable (M-stage CP0 write)
cp0_addr  in  5  CP0 register number for mfc0/mtc0
cp0_wdata  in  32  mtc0 data (M-stage forwarded rt)
cp0_rdata  out  32  mfc0 read data, combinational
m_pc  in  32  PC of the instruction in M
m_bd  in  1  M instruction is in a branch delay slot
m_exccode  in  5  exception code carried from E/M; 0 = none
m_eret  in  1  eret in M
hw_int  in  6  external interrupt lines, level-sensitive
req  out  1  take exception/interrupt this cycle, combinational
epc_out  out  32  EPC for eret redirect

Behaviour:
- Registers and reset values (reset low): SR(12) = {IM[15:10]=IM_RESET, EXL[1]=0, IE[0]=0}; Cause(13) = 0; EPC(14) = 0.
- Unimplemented bits read 0. Other addresses read 0; mtc0 writes to them are ignored.
- Cause.IP[15:10] <= effective hw_int every clock, regardless of other events.
- int_req = IE & ~EXL & |(IP_effective & IM). IP_effective is the live hw_int, not the registered IP.
- exc_req = ~EXL & (m_exccode != 0).
- req = int_req | exc_req. req is forced 0 while reset is low.
- Priority: interrupt over exception. Exception cycle (req=1), at the next edge:
  - EXL <= 1
  - Cause.ExcCode[6:2] <= int_req ? 0 : m_exccode
  - Cause.BD <= m_bd
  - EPC <= m_bd ? m_pc - 4 : m_pc, with bits [1:0] forced 0
- mtc0 is suppressed when req=1, because the writing instruction is flushed.
- mtc0 otherwise:
  - SR writes IM, EXL, IE only.
  - EPC writes [31:2], bits [1:0] forced 0.
  - Cause is read-only.
- m_eret with req=0: EXL <= 0 at the edge. If an mtc0 to SR is in the same cycle, EXL clear wins for the EXL bit.
- m_eret with EXL=1 can never raise req, because both terms are gated by ~EXL.
- epc_out = EPC. Bypass: when cp0_we & cp0_addr==14 & ~req, epc_out = {cp0_wdata[31:2],2'b00}, so an eret directly after mtc0 EPC is correct.
- cp0_rdata is a combinational mux on cp0_addr that shows the pre-edge register value. There is no write-through on read.
- Reset asserted mid-operation clears all state asynchronously and drops req the same instant.

Optional Feature:
- Macro CP0_TIMER_EN.
- With it defined:
  - Count(9) increments every clock and wraps 32'hFFFF_FFFF -> 0.
  - Compare(11) is a 32-bit register.
  - Both are mtc0-writable and reset to 0.
  - A write to Count loads cp0_wdata instead of incrementing that cycle.
  - When Count == Compare, timer_pending sets at the edge. It stays set until Compare is written.
  - Effective hw_int[5] = hw_int[5] | timer_pending.
- Without it: addresses 9/11 read 0 and ignore writes; effective hw_int = hw_int.

Decomposition:
- Package cp0_pkg holds:
  - register numbers: SR=12, CAUSE=13, EPC=14, COUNT=9, COMPARE=11
  - SR/Cause bit positions
  - ExcCode constants: INT=0, ADEL=4, ADES=5, RI=10, OV=12
  - handler vector 32'h4180
- One sub-module: cp0_timer (Count/Compare/pending), instantiated only under CP0_TIMER_EN.

Test Plan:
1. Reset low, then high. SR=Cause=EPC=0, req=0 with hw_int=6'h3F and m_exccode=12.
2. mtc0 SR=32'h0000_FC01, then hw_int=6'b000100 with m_pc=32'h3010, m_bd=0:
   - req=1 the same cycle
   - next edge: EPC=32'h3010, ExcCode=0, EXL=1, IP[12]=1
   - req=0 on the following cycle.
3. EXL=0, IE=0, m_exccode=12, m_pc=32'h3024, m_bd=1:
   - req=1
   - next edge: EPC=32'h3020, Cause.BD=1, ExcCode=12.
4. m_exccode=4 and an enabled interrupt pending in the same cycle: ExcCode latched 0 (interrupt wins). mtc0 SR issued that cycle is dropped.
5. EXL=1: mtc0 EPC=32'h3103 gives epc_out=32'h3100 the same cycle. Next cycle, m_eret gives EXL=0 after the edge, and req stays 0 throughout.
6. CP0_TIMER_EN: Compare=5, Count=0:
   - pending sets at the edge where Count==5
   - with IM[15]=IE=1, req asserts the next cycle
   - a write to Compare clears pending.
